fetch_unit: RTL and testbench

Instruction fetch and phase sequencer directly upstream of `decode`. Generates the four one-hot phase strobes `clk1`..`clk4` from a single clock, holds the program counter, and drives program-memory addresses. Latches each fetched 8-bit word into `inst_reg` for `decode`. Executes control transfers itself: class `2'b10` GOTO, and the skip request from execute.

---
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: four-phase instruction sequencer and program counter.
// Generates one-hot phase strobes Q1..Q4, fetches one 8-bit word per
// instruction cycle, and resolves GOTO and skip requests at the Q4 edge.
module fetch_unit #(
    parameter int unsigned          ADDR_W       = 6,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              skip,
    input  logic [7:0]        pm_data,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [7:0]        inst_reg,
    output logic              inst_valid,
    output logic              clk1,
    output logic              clk2,
    output logic              clk3,
    output logic              clk4
);

    typedef enum logic [3:0] {
        Q1 = 4'b0001,
        Q2 = 4'b0010,
        Q3 = 4'b0100,
        Q4 = 4'b1000
    } phase_t;

    phase_t            phase;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] goto_target;
    logic              is_goto;

    // GOTO target: 6-bit literal from the instruction, upper PC bits cleared
    always_comb begin
        goto_target      = '0;
        goto_target[5:0] = inst_reg[5:0];
    end

    // An injected NOP is class 00, so only a real fetched word can branch
    assign is_goto = inst_valid && (inst_reg[7:6] == 2'b10);

    assign {clk4, clk3, clk2, clk1} = phase;
    assign pm_addr                  = pc;

    // Phase ring plus PC / instruction latch, all frozen while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= Q1;
            pc         <= RESET_VECTOR;
            inst_reg   <= '0;
            inst_valid <= 1'b0;
        end else if (!stall) begin
            case (phase)
                Q1: phase <= Q2;
                Q2: phase <= Q3;
                Q3: phase <= Q4;
                Q4: begin
                    phase <= Q1;
                    if (is_goto) begin
                        pc         <= goto_target;
                        inst_reg   <= '0;
                        inst_valid <= 1'b0;
                    end else if (skip) begin
                        pc         <= pc + 1'b1;
                        inst_reg   <= '0;
                        inst_valid <= 1'b0;
                    end else begin
                        pc         <= pc + 1'b1;
                        inst_reg   <= pm_data;
                        inst_valid <= 1'b1;
                    end
                end
                default: phase <= Q1;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected post-Q4 state is queued
// per instruction cycle and compared when the cycle completes.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       skip = 1'b0;
    logic [7:0] pm_data;
    logic [5:0] pm_addr;
    logic [7:0] inst_reg;
    logic       inst_valid;
    logic       clk1, clk2, clk3, clk4;

    logic [7:0] mem [0:63];

    typedef struct packed {
        logic [7:0] ir;
        logic       v;
        logic [5:0] pa;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    assign pm_data = mem[pm_addr];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(6), .RESET_VECTOR(6'd0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .skip(skip),
        .pm_data(pm_data), .pm_addr(pm_addr),
        .inst_reg(inst_reg), .inst_valid(inst_valid),
        .clk1(clk1), .clk2(clk2), .clk3(clk3), .clk4(clk4)
    );

    function automatic exp_t mk(input logic [7:0] ir, input logic v, input logic [5:0] pa);
        exp_t e;
        e.ir = ir;
        e.v  = v;
        e.pa = pa;
        return e;
    endfunction

    task automatic load_program();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0]  = 8'h1C;
        mem[1]  = 8'hC5;
        mem[2]  = 8'h06;
        mem[3]  = 8'h8A;
        mem[4]  = 8'h55;
        mem[10] = 8'hC0;
        mem[11] = 8'h2A;
    endtask

    // Reset released at a falling edge; the next rising edge is the first after release
    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0;
        skip  = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] es;
        logic [5:0] ea;
        do_reset();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({clk4, clk3, clk2, clk1} !== 4'b0001 || pm_addr !== 6'd0 || inst_reg !== 8'h00 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midq3: strobes=%b pa=%0d ir=%h v=%b, required 0001 0 00 0",
                     {clk4, clk3, clk2, clk1}, pm_addr, inst_reg, inst_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            es = 4'b0001 << (k % 4);
            ea = (k < 4) ? 6'd0 : (k < 8) ? 6'd1 : 6'd2;
            checks++;
            if ({clk4, clk3, clk2, clk1} !== es || pm_addr !== ea) begin
                errors++;
                $display("FAIL phase_clk%0d: strobes=%b pa=%0d, required %b %0d",
                         k, {clk4, clk3, clk2, clk1}, pm_addr, es, ea);
            end
            if (k == 4) begin
                checks++;
                if (inst_reg !== 8'h1C || inst_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_fetch: ir=%h v=%b, required 1c 1", inst_reg, inst_valid);
                end
            end
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        do_reset();
        exp_q.push_back(mk(8'h1C, 1'b1, 6'd1));
        exp_q.push_back(mk(8'hC5, 1'b1, 6'd2));
        exp_q.push_back(mk(8'h06, 1'b1, 6'd3));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            repeat (4) @(negedge clk);
            checks++;
            if (inst_reg !== e.ir || inst_valid !== e.v || pm_addr !== e.pa || {clk4, clk3, clk2, clk1} !== 4'b0001) begin
                errors++;
                $display("FAIL seq_%0d: ir=%h v=%b pa=%0d ph=%b, required %h %b %0d 0001",
                         i, inst_reg, inst_valid, pm_addr, {clk4, clk3, clk2, clk1}, e.ir, e.v, e.pa);
            end
        end
    endtask

    // Continues from test_sequential: GOTO 10 sits at address 3
    task automatic test_goto();
        exp_t e;
        exp_q.push_back(mk(8'h8A, 1'b1, 6'd4));
        exp_q.push_back(mk(8'h00, 1'b0, 6'd10));
        exp_q.push_back(mk(8'hC0, 1'b1, 6'd11));
        exp_q.push_back(mk(8'h2A, 1'b1, 6'd12));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            repeat (4) @(negedge clk);
            checks++;
            if (inst_reg !== e.ir || inst_valid !== e.v || pm_addr !== e.pa) begin
                errors++;
                $display("FAIL goto_%0d: ir=%h v=%b pa=%0d, required %h %b %0d",
                         i, inst_reg, inst_valid, pm_addr, e.ir, e.v, e.pa);
            end
        end
    endtask

    // Skip pulsed in Q2 of cycle 0 (must be ignored) and in Q4 of cycle 2
    task automatic test_skip();
        exp_t e;
        do_reset();
        exp_q.push_back(mk(8'h1C, 1'b1, 6'd1));
        exp_q.push_back(mk(8'hC5, 1'b1, 6'd2));
        exp_q.push_back(mk(8'h00, 1'b0, 6'd3));
        exp_q.push_back(mk(8'h8A, 1'b1, 6'd4));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            @(negedge clk);
            if (i == 0) skip = 1'b1;
            @(negedge clk);
            skip = 1'b0;
            @(negedge clk);
            if (i == 2) skip = 1'b1;
            @(negedge clk);
            skip = 1'b0;
            checks++;
            if (inst_reg !== e.ir || inst_valid !== e.v || pm_addr !== e.pa) begin
                errors++;
                $display("FAIL skip_%0d: ir=%h v=%b pa=%0d, required %h %b %0d",
                         i, inst_reg, inst_valid, pm_addr, e.ir, e.v, e.pa);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (5) @(negedge clk);
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({clk4, clk3, clk2, clk1} !== 4'b0010 || pm_addr !== 6'd1 || inst_reg !== 8'h1C || inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_%0d: ph=%b pa=%0d ir=%h v=%b, required 0010 1 1c 1",
                         k, {clk4, clk3, clk2, clk1}, pm_addr, inst_reg, inst_valid);
            end
        end
        stall = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({clk4, clk3, clk2, clk1} !== 4'b1000 || inst_reg !== 8'h1C || pm_addr !== 6'd1) begin
            errors++;
            $display("FAIL stall_shift_q4: ph=%b ir=%h pa=%0d, required 1000 1c 1",
                     {clk4, clk3, clk2, clk1}, inst_reg, pm_addr);
        end
        @(negedge clk);
        checks++;
        if ({clk4, clk3, clk2, clk1} !== 4'b0001 || inst_reg !== 8'hC5 || pm_addr !== 6'd2) begin
            errors++;
            $display("FAIL stall_shift_edge: ph=%b ir=%h pa=%0d, required 0001 c5 2",
                     {clk4, clk3, clk2, clk1}, inst_reg, pm_addr);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (20) @(negedge clk);
        checks++;
        if (inst_reg !== 8'h00 || inst_valid !== 1'b0 || pm_addr !== 6'd10) begin
            errors++;
            $display("FAIL flush_state: ir=%h v=%b pa=%0d, required 00 0 10", inst_reg, inst_valid, pm_addr);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pm_addr !== 6'd0 || inst_reg !== 8'h00 || inst_valid !== 1'b0 || {clk4, clk3, clk2, clk1} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset: pa=%0d ir=%h v=%b ph=%b, required 0 00 0 0001",
                     pm_addr, inst_reg, inst_valid, {clk4, clk3, clk2, clk1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // GOTO 62 at address 3 walks the PC across the top of memory
    task automatic test_wrap();
        exp_t e;
        mem[3]  = 8'hBE;
        mem[62] = 8'h11;
        mem[63] = 8'h22;
        do_reset();
        exp_q.push_back(mk(8'h1C, 1'b1, 6'd1));
        exp_q.push_back(mk(8'hC5, 1'b1, 6'd2));
        exp_q.push_back(mk(8'h06, 1'b1, 6'd3));
        exp_q.push_back(mk(8'hBE, 1'b1, 6'd4));
        exp_q.push_back(mk(8'h00, 1'b0, 6'd62));
        exp_q.push_back(mk(8'h11, 1'b1, 6'd63));
        exp_q.push_back(mk(8'h22, 1'b1, 6'd0));
        exp_q.push_back(mk(8'h1C, 1'b1, 6'd1));
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            repeat (4) @(negedge clk);
            checks++;
            if (inst_reg !== e.ir || inst_valid !== e.v || pm_addr !== e.pa) begin
                errors++;
                $display("FAIL wrap_%0d: ir=%h v=%b pa=%0d, required %h %b %0d",
                         i, inst_reg, inst_valid, pm_addr, e.ir, e.v, e.pa);
            end
        end
    endtask

    initial begin
        load_program();
        test_reset();
        test_sequential();
        test_goto();
        test_skip();
        test_stall();
        test_async_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
